// File: rtl/ram4k_arbiter_pkg.sv
// Shared definitions for the RAM4k two-requester arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding (IDLE=0, ACCESS=1, DONE=2), owner constants,
//           and default word/address widths that match the RAM4k macro.
package ram4k_arbiter_pkg;

  localparam int RAM4K_DATA_W = 16;
  localparam int RAM4K_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

endpackage

// File: rtl/ram4k_arbiter_rr_pick2.sv
// Two-way request picker: round-robin on contention, single requester always wins.
// Latency: purely combinational.
// Backpressure: none; the caller samples grant/valid only when it can start an access.
// Ports: req0, req1 (requests), last_grant (owner of the previous access),
//        grant (winning owner, OWNER_0/OWNER_1), valid (any request present).
// Build option ARB_FIXED_PRIO_EN: requester 0 always wins contention; last_grant is ignored.
module rr_pick2
  import ram4k_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

`ifdef ARB_FIXED_PRIO_EN
  // History is kept by the caller but plays no part in fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    valid = req0 | req1;
    grant = OWNER_0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      grant = OWNER_0;
`else
      // Whoever did not get the previous access goes next.
      grant = ~last_grant;
`endif
    end else if (req1) begin
      grant = OWNER_1;
    end
  end

endmodule

// File: rtl/ram4k_arbiter.sv
// Shares one RAM4k (16b x 4096) between a CPU data port (req0) and a DMA/screen engine (req1).
// Latency: request sampled at edge N -> RAM access in cycle N+1 -> one-cycle ack in cycle N+2; one access per 3 cycles.
// Backpressure: requester holds req until its ack; inputs are sampled only in IDLE, the loser simply waits.
// Ports: clk, reset (sync, active-high); reqX/weX/addrX/wdataX in, ackX out for X=0,1;
//        rdata (read data, valid in the read's ack cycle, held otherwise);
//        ram_in/ram_load/ram_sel drive the RAM4k, ram_out is its combinational read port.
// Build option ARB_FIXED_PRIO_EN: requester 0 always wins contention (see rr_pick2).
module ram4k_arbiter
  import ram4k_arbiter_pkg::*;
#(
  parameter int DATA_W = RAM4K_DATA_W,
  parameter int ADDR_W = RAM4K_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_sel,
  input  logic [DATA_W-1:0] ram_out
);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                load_q, load_d;
  logic [ADDR_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]   in_q, in_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                pick_grant;
  logic                pick_valid;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // Next-state and datapath capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    load_d       = load_q;
    sel_d        = sel_q;
    in_d         = in_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // Requester inputs are captured here only; later changes are ignored.
          owner_d = pick_grant;
          if (pick_grant == OWNER_1) begin
            sel_d  = addr1;
            in_d   = wdata1;
            load_d = we1;
          end else begin
            sel_d  = addr0;
            in_d   = wdata0;
            load_d = we0;
          end
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // RAM read port is combinational on the registered select, so the
        // data is ready to capture at the closing edge of this cycle.
        if (!load_q) begin
          rdata_d = ram_out;
        end
        state_d = DONE;
      end

      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_0;
      last_grant_q <= OWNER_1;  // so requester 0 wins the first contention
      load_q       <= 1'b0;
      sel_q        <= '0;
      in_q         <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      load_q       <= load_d;
      sel_q        <= sel_d;
      in_q         <= in_d;
      rdata_q      <= rdata_d;
    end
  end

  // Reset gates the write strobe directly so a write whose ACCESS cycle
  // coincides with reset never reaches the RAM.
  assign ram_load = (state_q == ACCESS) & load_q & ~reset;
  assign ram_sel  = sel_q;
  assign ram_in   = in_q;
  assign rdata    = rdata_q;

  // Only one owner can be in DONE, so the acks are mutually exclusive.
  assign ack0 = (state_q == DONE) & (owner_q == OWNER_0);
  assign ack1 = (state_q == DONE) & (owner_q == OWNER_1);

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Testbench for ram4k_arbiter with a behavioural RAM4k and an expected-transaction queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram4k_arbiter;
  import ram4k_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, ack0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          req1, we1, ack1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] rdata, ram_in, ram_out;
  logic          ram_load;
  logic [AW-1:0] ram_sel;

  always #5 clk = ~clk;

  ram4k_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .ram_in(ram_in), .ram_load(ram_load), .ram_sel(ram_sel),
    .ram_out(ram_out)
  );

  // Behavioural RAM4k: combinational read, write on rising edge when load.
  logic [DW-1:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] <= '0;
  always @(posedge clk) if (ram_load) mem[ram_sel] <= ram_in;
  assign ram_out = mem[ram_sel];

  typedef struct packed {
    logic          owner;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and record the transaction it should produce.
  // For writes d is the write data, for reads the expected rdata.
  task automatic issue(input logic own, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    if (own == OWNER_1) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    e.owner = own; e.rd = ~we; e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic drop(input logic own);
    if (own == OWNER_1) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = 'x;
  endtask

  // Bounded wait for an ack; who stays X if none arrives within budget.
  task automatic wait_ack(input int budget, output logic who, output int cyc,
                          output logic ovl, output logic load_seen);
    who = 1'bx; cyc = 0; ovl = 1'b0; load_seen = 1'b0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (ram_load) load_seen = 1'b1;
      if (ack0 && ack1) ovl = 1'b1;
      if (ack0 || ack1) begin
        who = ack1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b expected 00", ack0, ack1); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
    checks++; if (ram_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", ram_load); end
    checks++; if (ram_sel !== '0 || ram_in !== '0) begin errors++; $display("FAIL reset_sel_in: got %h/%h expected 000/0000", ram_sel, ram_in); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    exp_t e;
    issue(OWNER_0, 1'b1, 12'h958, 16'hF00D);
    tick();
    checks++; if (ram_load !== 1'b1) begin errors++; $display("FAIL write_load_access: got %b expected 1", ram_load); end
    checks++; if (ram_sel !== 12'h958 || ram_in !== 16'hF00D) begin errors++; $display("FAIL write_sel_in: got %h/%h expected 958/f00d", ram_sel, ram_in); end
    tick();
    pop_exp(e);
    checks++; if ({ack1, ack0} !== {e.owner, ~e.owner}) begin errors++; $display("FAIL write_ack_n2: got ack1/ack0 %b%b expected owner %b", ack1, ack0, e.owner); end
    checks++; if (ram_load !== 1'b0) begin errors++; $display("FAIL write_load_done: got %b expected 0", ram_load); end
    drop(OWNER_0);
    tick();
  endtask

  task automatic test_readback();
    exp_t e; logic who; int cyc; logic ovl; logic ld;
    issue(OWNER_1, 1'b0, 12'h958, 16'hF00D);
    wait_ack(8, who, cyc, ovl, ld);
    pop_exp(e);
    checks++; if (who !== e.owner || cyc != 2) begin errors++; $display("FAIL read_ack: got owner %b after %0d cycles expected owner %b after 2", who, cyc, e.owner); end
    checks++; if (rdata !== e.data) begin errors++; $display("FAIL read_data: got %h expected %h", rdata, e.data); end
    checks++; if (ld !== 1'b0) begin errors++; $display("FAIL read_load: got %b expected 0", ld); end
    drop(OWNER_1);
    tick();
  endtask

  task automatic test_edges();
    exp_t e; logic who; int cyc; logic ovl; logic ld;
    logic [AW-1:0] addrs [4] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
    logic [DW-1:0] dats  [4] = '{16'hA000, 16'hBFFF, 16'hA000, 16'hBFFF};
    logic          owns  [4] = '{OWNER_0, OWNER_1, OWNER_1, OWNER_0};
    logic          wes   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      issue(owns[k], wes[k], addrs[k], dats[k]);
      wait_ack(8, who, cyc, ovl, ld);
      pop_exp(e);
      checks++; if (who !== e.owner || cyc != 2) begin errors++; $display("FAIL edge_ack[%0d]: got owner %b after %0d expected owner %b after 2", k, who, cyc, e.owner); end
      if (e.rd) begin
        checks++; if (rdata !== e.data) begin errors++; $display("FAIL edge_rdata[%0d]: got %h expected %h", k, rdata, e.data); end
      end
      drop(owns[k]);
      tick();
    end
    // Request withdrawn during ACCESS: the access still completes and acks.
    issue(owns[3], wes[3], addrs[3], dats[3]);
    tick();
    drop(owns[3]);
    wait_ack(8, who, cyc, ovl, ld);
    pop_exp(e);
    checks++; if (who !== e.owner || cyc != 1) begin errors++; $display("FAIL drop_ack: got owner %b after %0d expected owner %b after 1", who, cyc, e.owner); end
    checks++; if (rdata !== e.data) begin errors++; $display("FAIL drop_rdata: got %h expected %h", rdata, e.data); end
    tick();
  endtask

  task automatic test_contention();
    exp_t e; logic who; int cyc; logic ovl; logic ld;
    exp_t ne;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h958; wdata0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'hFFF; wdata1 = 16'h0000;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      ne.owner = OWNER_0;
`else
      ne.owner = (k % 2 == 1) ? OWNER_1 : OWNER_0;
`endif
      ne.rd = 1'b1;
      ne.data = (ne.owner == OWNER_1) ? 16'hBFFF : 16'hF00D;
      sb_q.push_back(ne);
      wait_ack(8, who, cyc, ovl, ld);
      pop_exp(e);
      checks++; if (who !== e.owner || cyc != ((k == 0) ? 2 : 3)) begin errors++; $display("FAIL contend_grant[%0d]: got owner %b after %0d expected owner %b", k, who, cyc, e.owner); end
      checks++; if (rdata !== e.data || ovl !== 1'b0) begin errors++; $display("FAIL contend_data[%0d]: got %h overlap %b expected %h overlap 0", k, rdata, ovl, e.data); end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    exp_t e; logic who; int cyc; logic ovl; logic ld; logic any_ack;
    issue(OWNER_0, 1'b1, 12'h02B, 16'h1234);
    wait_ack(8, who, cyc, ovl, ld);
    pop_exp(e);
    checks++; if (who !== e.owner) begin errors++; $display("FAIL pre_write_ack: got %b expected %b", who, e.owner); end
    drop(OWNER_0);
    tick();
    // This write is expected to be killed by reset, so nothing is queued.
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h02B; wdata1 = 16'hDEAF;
    tick();
    checks++; if (ram_load !== 1'b1) begin errors++; $display("FAIL midrst_load_before: got %b expected 1", ram_load); end
    reset = 1'b1;
    #1;
    checks++; if (ram_load !== 1'b0) begin errors++; $display("FAIL midrst_load_gated: got %b expected 0", ram_load); end
    tick();
    reset = 1'b0;
    req1 = 1'b0;
    any_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ack0 || ack1) any_ack = 1'b1;
      tick();
    end
    checks++; if (any_ack !== 1'b0) begin errors++; $display("FAIL midrst_no_ack: got %b expected 0", any_ack); end
    issue(OWNER_0, 1'b0, 12'h02B, 16'h1234);
    wait_ack(8, who, cyc, ovl, ld);
    pop_exp(e);
    checks++; if (who !== e.owner || cyc != 2) begin errors++; $display("FAIL midrst_read_ack: got owner %b after %0d expected owner %b after 2", who, cyc, e.owner); end
    checks++; if (rdata !== e.data) begin errors++; $display("FAIL midrst_old_value: got %h expected %h", rdata, e.data); end
    drop(OWNER_0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_single_write();
    test_readback();
    test_edges();
    test_contention();
    test_reset_mid_write();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL leftover_expected: got %0d entries expected 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
